// File: rtl/vector_mem_unit_if.sv
// Memory beat bus between the vector memory unit and a 16-bit data memory.
//   mem_addr  : beat address
//   mem_wdata : beat write data (stores)
//   mem_rdata : beat read data, valid when mem_ready=1 (loads)
//   mem_re    : read strobe
//   mem_we    : write strobe
//   mem_ready : beat accepted/complete in this cycle
// master = vector_mem_unit side, slave = memory side.
interface vector_mem_unit_if #(
    parameter int ADDR_W = 16,
    parameter int LANE_W = 16
);
    logic [ADDR_W-1:0] mem_addr;
    logic [LANE_W-1:0] mem_wdata;
    logic [LANE_W-1:0] mem_rdata;
    logic              mem_re;
    logic              mem_we;
    logic              mem_ready;

    modport master (
        output mem_addr, mem_wdata, mem_re, mem_we,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_re, mem_we,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/vector_mem_unit.sv
// Vector memory stage: moves one LANES x LANE_W vector between the register
// file and a LANE_W-wide data memory, one lane per beat, stalling on mem_ready.
//   clk, rst_n  : clock, async active-low reset
//   start       : request, sampled only in IDLE (with is_store/addr/store_data)
//   is_store    : 1 = VST (write memory), 0 = VLD (read memory)
//   addr        : base beat address
//   store_data  : vector to store, lane i in [i]
//   busy        : high in XFER and DONE
//   done        : one-cycle completion pulse
//   load_data   : loaded vector, lane i in [i]
//   mem         : memory beat bus (master side)

// One lane of load_data; captures read data when its beat completes.
module vmu_lane_reg #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (wr) q <= d;
    end
endmodule

module vector_mem_unit #(
    parameter int LANES  = 16,
    parameter int LANE_W = 16,
    parameter int ADDR_W = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          is_store,
    input  logic [ADDR_W-1:0]             addr,
    input  logic [LANES-1:0][LANE_W-1:0]  store_data,
    output logic                          busy,
    output logic                          done,
    output logic [LANES-1:0][LANE_W-1:0]  load_data,
    vector_mem_unit_if.master             mem
);
    localparam int LW = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t                      state;
    logic [LW-1:0]               lane;
    logic [ADDR_W-1:0]           base;
    logic                        store_q;
    logic [LANES-1:0][LANE_W-1:0] sdata_q;

    logic          last_lane;
    logic          beat;
    logic [LW-1:0] lane_nxt;

    assign last_lane = (lane == LW'(LANES - 1));
    assign beat      = (state == XFER) && mem.mem_ready;
    assign lane_nxt  = lane + 1'b1;

    // Address/strobes/wdata are registered one beat ahead so they stay
    // stable across stall cycles without any extra hold logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            lane          <= '0;
            base          <= '0;
            store_q       <= 1'b0;
            sdata_q       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            mem.mem_re    <= 1'b0;
            mem.mem_we    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= XFER;
                        busy          <= 1'b1;
                        lane          <= '0;
                        base          <= addr;
                        store_q       <= is_store;
                        sdata_q       <= store_data;
                        mem.mem_addr  <= addr;
                        mem.mem_re    <= !is_store;
                        mem.mem_we    <= is_store;
                        mem.mem_wdata <= is_store ? store_data[0] : '0;
                    end
                end
                XFER: begin
                    if (mem.mem_ready) begin
                        if (last_lane) begin
                            state         <= DONE;
                            done          <= 1'b1;
                            mem.mem_re    <= 1'b0;
                            mem.mem_we    <= 1'b0;
                            mem.mem_wdata <= '0;
                        end else begin
                            lane         <= lane_nxt;
                            // ADDR_W-bit sum wraps modulo 2^ADDR_W
                            mem.mem_addr <= base + ADDR_W'(lane_nxt);
                            if (store_q) mem.mem_wdata <= sdata_q[lane_nxt];
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic wr;
        assign wr = beat && !store_q && (lane == LW'(g));
        vmu_lane_reg #(.W(LANE_W)) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .wr    (wr),
            .d     (mem.mem_rdata),
            .q     (load_data[g])
        );
    end
endmodule

// File: tb/tb_vector_mem_unit.sv
module tb_vector_mem_unit;
    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                is_store;
    logic [15:0]         addr;
    logic [15:0][15:0]   store_data;
    logic                busy;
    logic                done;
    logic [15:0][15:0]   load_data;

    vector_mem_unit_if #(.ADDR_W(16), .LANE_W(16)) mif();

    vector_mem_unit #(.LANES(16), .LANE_W(16), .ADDR_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_store   (is_store),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .mem        (mif)
    );

    initial forever #5 clk = ~clk;

    // memory model: preloaded only, read combinationally
    logic [15:0] mem_model [0:65535];
    assign mif.mem_rdata = mem_model[mif.mem_addr];

    int cyc = 0;
    int t0 = 0;
    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    logic stall_mode = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic        we;
        logic [15:0] a;
        logic [15:0] d;
    } beat_t;
    beat_t sb[$];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic st, input logic [15:0] base, input logic [15:0][15:0] sd);
        for (int i = 0; i < 16; i++)
            sb.push_back('{st, 16'(base + 16'(i)), st ? sd[i] : 16'h0});
    endtask

    task automatic wait_done(input int prev);
        int k = 0;
        while (done_cnt == prev && k < 100) begin
            step();
            k++;
        end
        check("done_seen", 256'(done_cnt), 256'(prev + 1));
    endtask

    task automatic run_xfer(input logic st, input logic [15:0] a,
                            input logic [15:0][15:0] sd, input int exp_done);
        int prev;
        push(st, a, sd);
        step();
        start = 1'b1; is_store = st; addr = a; store_data = sd;
        t0 = cyc;
        prev = done_cnt;
        step();
        start = 1'b0;
        wait_done(prev);
        check("done_cyc", 256'(done_cyc), 256'(exp_done));
        check("busy_after", 256'(busy), 256'(0));
        check("done_after", 256'(done), 256'(0));
        check("sb_drained", 256'(sb.size()), 256'(0));
    endtask

    // mem_ready: always high, or low on odd cycles of the transfer
    initial begin
        mif.mem_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            mif.mem_ready = stall_mode ? (((cyc - t0) % 2) == 0) : 1'b1;
        end
    end

    // beat monitor: exclusivity, stall hold, scoreboard, done timing
    logic        stalled = 1'b0;
    logic [15:0] stall_addr = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            beat_t e;
            check("re_we_excl", 256'(mif.mem_re && mif.mem_we), 256'(0));
            if (stalled && (mif.mem_re || mif.mem_we))
                check("stall_hold_addr", 256'(mif.mem_addr), 256'(stall_addr));
            stalled    = (mif.mem_re || mif.mem_we) && !mif.mem_ready;
            stall_addr = mif.mem_addr;
            if ((mif.mem_re || mif.mem_we) && mif.mem_ready) begin
                check("sb_nonempty", 256'(sb.size() != 0), 256'(1));
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("beat_addr", 256'(mif.mem_addr), 256'(e.a));
                    check("beat_we", 256'(mif.mem_we), 256'(e.we));
                    if (e.we) check("beat_wdata", 256'(mif.mem_wdata), 256'(e.d));
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc - t0;
            end
        end
    end

    logic [15:0][15:0] exp1, exp3, exp4, exp5, sd2, sd6;

    initial begin
        rst_n = 1'b0; start = 1'b0; is_store = 1'b0; addr = '0; store_data = '0;
        for (int i = 0; i < 16; i++) begin
            mem_model[16'h0100 + i]       = 16'hA000 + 16'(i);
            mem_model[16'h0400 + i]       = 16'h5A00 ^ 16'(i * 7);
            mem_model[16'(16'hFFFE + i)]  = 16'hC000 + 16'(i);
            mem_model[16'h0500 + i]       = 16'h7700 + 16'(i);
            exp1[i] = 16'hA000 + 16'(i);
            exp3[i] = 16'h5A00 ^ 16'(i * 7);
            exp4[i] = 16'hC000 + 16'(i);
            exp5[i] = 16'h7700 + 16'(i);
            sd2[i]  = 16'(i * 3);
            sd6[i]  = 16'hBEE0 + 16'(i);
        end
        repeat (3) step();
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_done", 256'(done), 256'(0));
        check("rst_re", 256'(mif.mem_re), 256'(0));
        check("rst_we", 256'(mif.mem_we), 256'(0));
        check("rst_addr", 256'(mif.mem_addr), 256'(0));
        check("rst_wdata", 256'(mif.mem_wdata), 256'(0));
        check("rst_load", load_data, 256'(0));
        rst_n = 1'b1;
        step();

        // 1: plain load
        run_xfer(1'b0, 16'h0100, '0, 17);
        check("t1_load", load_data, exp1);

        // 2: store leaves load_data alone
        run_xfer(1'b1, 16'h0200, sd2, 17);
        check("t2_load_kept", load_data, exp1);

        // 3: ready low every other cycle
        stall_mode = 1'b1;
        run_xfer(1'b0, 16'h0400, '0, 33);
        stall_mode = 1'b0;
        check("t3_load", load_data, exp3);

        // 4: address wrap
        run_xfer(1'b0, 16'hFFFE, '0, 17);
        check("t4_load", load_data, exp4);

        // 5: start while busy ignored; start right after done accepted
        begin
            int prev;
            push(1'b0, 16'h0100, '0);
            step();
            start = 1'b1; is_store = 1'b0; addr = 16'h0100;
            t0 = cyc; prev = done_cnt;
            step(); start = 1'b0;                  // cycle 1
            repeat (4) step();                     // cycle 5
            start = 1'b1; is_store = 1'b1; addr = 16'h0300;
            step(); start = 1'b0;                  // cycle 6
            repeat (11) step();                    // cycle 17
            start = 1'b1; is_store = 1'b0; addr = 16'h0500;
            step();                                // cycle 18
            check("t5_one_done", 256'(done_cnt), 256'(prev + 1));
            check("t5_done_cyc", 256'(done_cyc), 256'(17));
            check("t5_idle_18", 256'(busy), 256'(0));
            check("t5_load1", load_data, exp1);
            push(1'b0, 16'h0500, '0);
            t0 = cyc; prev = done_cnt;
            step(); start = 1'b0;
            wait_done(prev);
            check("t5_done2_cyc", 256'(done_cyc), 256'(17));
            check("t5_load2", load_data, exp5);
            check("t5_sb_drained", 256'(sb.size()), 256'(0));
        end

        // 6: reset in the middle of a store
        begin
            int prev;
            push(1'b1, 16'h0300, sd6);
            step();
            start = 1'b1; is_store = 1'b1; addr = 16'h0300; store_data = sd6;
            t0 = cyc; prev = done_cnt;
            step(); start = 1'b0;
            repeat (7) step();                     // cycle 8
            check("t6_busy_pre", 256'(busy), 256'(1));
            rst_n = 1'b0;
            #1;
            check("t6_we", 256'(mif.mem_we), 256'(0));
            check("t6_re", 256'(mif.mem_re), 256'(0));
            check("t6_busy", 256'(busy), 256'(0));
            check("t6_load", load_data, 256'(0));
            check("t6_sb_left", 256'(sb.size()), 256'(9));
            sb.delete();
            repeat (2) step();
            rst_n = 1'b1;
            repeat (20) step();
            check("t6_no_done", 256'(done_cnt), 256'(prev));
            check("t6_idle", 256'(busy), 256'(0));
            check("t6_we_idle", 256'(mif.mem_we), 256'(0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
